lcd_fifo_wr_arbiter: RTL and testbench
======================================

LCD_FIFO_WR_ARBITER -- requirements
Module: lcd_fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_ALMOSTFULL_DEPTH, default 768: fill level at or above which writing stops.
REQ-002 Parameter FIFO_ALMOSTEMPTY_DEPTH, default 128: fill level below which writing resumes.
REQ-003 Parameter BURST_LEN, default 64: maximum beats per grant.
REQ-004 Parameter DATA_W, default 24: pixel data width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 fifo_wr_clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 src_req  in  2  per-source burst request, bit i = source i.
REQ-009 src_data_en  in  2  per-source data valid, AXI-stream style.
REQ-010 src_last  in  2  per-source end-of-line marker, qualified by a write.
REQ-011 src_data0, src_data1  in  DATA_W each  source pixel data.
REQ-012 src_request  out  2  per-source data request (ready); one-hot or zero.
REQ-013 fifo_wr_en  out  1  FIFO write strobe.
REQ-014 fifo_din  out  DATA_W  FIFO write data.
REQ-015 fifo_full  in  1  FIFO full flag, active-high.
REQ-016 fifo_wr_cnt  in  10  FIFO write-side fill count.
REQ-017 grant  out  2  registered one-hot owner, zero when idle.

Function
REQ-018 Watermark flag wr_ready: cleared when fifo_wr_cnt >= FIFO_ALMOSTFULL_DEPTH or fifo_full; otherwise set when fifo_wr_cnt < FIFO_ALMOSTEMPTY_DEPTH; otherwise held; clear wins.
REQ-019 FSM has two states, IDLE and BURST; reset state IDLE.
REQ-020 IDLE -> BURST when wr_ready=1 and src_req!=0; grant loads the winner on that edge.
REQ-021 Arbitration is round-robin: on simultaneous requests, the source not most recently granted wins; after reset, source 0 has priority.
REQ-022 In BURST, src_request[g] = wr_ready & ~fifo_full (combinational), where g is the granted source; the non-granted bit is 0.
REQ-023 fifo_wr_en = src_request[g] & src_data_en[g]; fifo_din = data of g when in BURST, else 0.
REQ-024 src_data_en from a non-granted source, or while src_request is low, is ignored and produces no write.
REQ-025 A 6-bit-or-wider beat counter clears on entry to BURST and increments on each write.
REQ-026 BURST -> IDLE on a write with beat count = BURST_LEN-1, on a write with src_last[g]=1, or when src_req[g] drops with no write that cycle; grant clears and the round-robin pointer records g.
REQ-027 If wr_ready falls mid-burst, the block pauses (no requests) and keeps the grant; it resumes after wr_ready re-sets.
REQ-028 Latency: grant asserts 1 cycle after a qualifying src_req; the first write can occur in the cycle grant is high.
REQ-029 fifo_wr_en SHALL never be 1 while fifo_full=1.

Reset
REQ-030 While rst=1: grant=0, src_request=0, fifo_wr_en=0, fifo_din=0, wr_ready=0, beat counter=0, state IDLE, round-robin pointer set to favour source 0.
REQ-031 Reset asserted mid-burst takes effect on the next edge; the partial burst is abandoned and no write occurs while rst=1.

Structure
REQ-032 Shared package lcd_pkg holds the FSM state encoding and the default watermark and burst constants.
REQ-033 The hysteresis flag (REQ-018) is a sub-module named lcd_fifo_watermark, reusable by the read side.

Verification
REQ-034 Single source: src_req=01, src_data_en held at 1, fill count 0 -> grant=01 after 1 cycle, exactly 64 writes, then IDLE.
REQ-035 Both sources request continuously -> grants alternate 01, 10, 01, ... with 64 beats each; source 0 wins first after reset.
REQ-036 Fill count steps 0 -> 768 mid-burst -> src_request=0 and writes stop; fill count 127 -> writing resumes under the same grant.
REQ-037 src_last=1 on beat 10 of source 1 -> burst ends after 11 writes; next grant goes to source 0 if it is requesting.
REQ-038 fifo_full=1 with count 500 -> no write in any cycle; src_data_en=1 on the non-granted source -> no write.
REQ-039 rst=1 on beat 30 -> all outputs 0 on the next edge; after release, source 0 wins a tie.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD FIFO write/read side: FSM encoding,
// default watermarks and burst length, and the round-robin pick helper.
package lcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int LCD_ALMOSTFULL_DEPTH  = 768;
  localparam int LCD_ALMOSTEMPTY_DEPTH = 128;
  localparam int LCD_BURST_LEN         = 64;
  localparam int LCD_FIFO_CNT_W        = 10;
  localparam int LCD_NUM_SRC           = 2;

  // With both sources asking, the one not served last wins; otherwise the lone requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_src);
    if (req == 2'b11) rr_pick = last_src ? 2'b01 : 2'b10;
    else              rr_pick = req;
  endfunction

endpackage

// File: rtl/lcd_fifo_wr_arbiter_if.sv
// Source/FIFO handshake bundle of the LCD FIFO write arbiter.
interface lcd_fifo_wr_arbiter_if
  import lcd_pkg::*;
#(
  parameter int DATA_W = 24
);

  logic [1:0]                src_req;
  logic [1:0]                src_data_en;
  logic [1:0]                src_last;
  logic [DATA_W-1:0]         src_data0;
  logic [DATA_W-1:0]         src_data1;
  logic [1:0]                src_request;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_full;
  logic [LCD_FIFO_CNT_W-1:0] fifo_wr_cnt;
  logic [1:0]                grant;

  modport master (
    input  src_req, src_data_en, src_last, src_data0, src_data1, fifo_full, fifo_wr_cnt,
    output src_request, fifo_wr_en, fifo_din, grant
  );

  modport slave (
    output src_req, src_data_en, src_last, src_data0, src_data1, fifo_full, fifo_wr_cnt,
    input  src_request, fifo_wr_en, fifo_din, grant
  );

endinterface

// File: rtl/lcd_fifo_watermark.sv
// Hysteresis flag over a FIFO fill count: drops at the almost-full mark or on
// full, rises again only once the level falls below the almost-empty mark.
module lcd_fifo_watermark #(
  parameter int FULL_DEPTH  = 768,
  parameter int EMPTY_DEPTH = 128,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] fifo_cnt,
  input  logic             fifo_full,
  output logic             ready
);

  logic ready_reg, ready_next;

  always_comb begin
    ready_next = ready_reg;
    if ((int'(fifo_cnt) >= FULL_DEPTH) || fifo_full) ready_next = 1'b0;
    else if (int'(fifo_cnt) < EMPTY_DEPTH)           ready_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ready_reg <= 1'b0;
    else     ready_reg <= ready_next;
  end

  assign ready = ready_reg;

endmodule

// File: rtl/lcd_fifo_wr_arbiter.sv
// Two-source round-robin burst arbiter feeding the LCD pixel FIFO write port,
// throttled by a watermark flag and hard-gated by fifo_full.
module lcd_fifo_wr_arbiter
  import lcd_pkg::*;
#(
  parameter int FIFO_ALMOSTFULL_DEPTH  = LCD_ALMOSTFULL_DEPTH,
  parameter int FIFO_ALMOSTEMPTY_DEPTH = LCD_ALMOSTEMPTY_DEPTH,
  parameter int BURST_LEN              = LCD_BURST_LEN,
  parameter int DATA_W                 = 24
) (
  input  logic                  fifo_wr_clk,
  input  logic                  rst,
  lcd_fifo_wr_arbiter_if.master bus
);

  localparam int BEAT_W = ($clog2(BURST_LEN) < 6) ? 6 : $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic              wr_ready;
  arb_state_t        state_reg, state_next;
  logic [1:0]        grant_reg, grant_next;
  logic              last_src_reg, last_src_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic              g_idx;
  logic              in_burst;
  logic              flow_ok;
  logic [1:0]        request_vec;
  logic              wr_en;
  logic              end_burst;

  lcd_fifo_watermark #(
    .FULL_DEPTH  (FIFO_ALMOSTFULL_DEPTH),
    .EMPTY_DEPTH (FIFO_ALMOSTEMPTY_DEPTH),
    .CNT_W       (LCD_FIFO_CNT_W)
  ) u_watermark (
    .clk       (fifo_wr_clk),
    .rst       (rst),
    .fifo_cnt  (bus.fifo_wr_cnt),
    .fifo_full (bus.fifo_full),
    .ready     (wr_ready)
  );

  assign g_idx    = grant_reg[1];
  // Outputs are masked by rst so an abandoned burst cannot write in the reset cycle.
  assign in_burst = (state_reg == ST_BURST) && !rst;
  assign flow_ok  = in_burst && wr_ready && !bus.fifo_full;

  generate
    for (genvar gi = 0; gi < LCD_NUM_SRC; gi++) begin : g_req
      assign request_vec[gi] = flow_ok & grant_reg[gi];
    end
  endgenerate

  assign wr_en           = |(request_vec & bus.src_data_en);
  assign bus.src_request = request_vec;
  assign bus.fifo_wr_en  = wr_en;
  assign bus.fifo_din    = in_burst ? (g_idx ? bus.src_data1 : bus.src_data0) : '0;
  assign bus.grant       = grant_reg;

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_src_next = last_src_reg;
    beat_next     = beat_reg;
    end_burst     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wr_ready && (bus.src_req != 2'b00)) begin
          state_next = ST_BURST;
          grant_next = rr_pick(bus.src_req, last_src_reg);
          beat_next  = '0;
        end
      end
      ST_BURST: begin
        if (wr_en) begin
          beat_next = beat_reg + 1'b1;
          if ((beat_reg == LAST_BEAT) || bus.src_last[g_idx]) end_burst = 1'b1;
        end else if (!bus.src_req[g_idx]) begin
          end_burst = 1'b1;
        end
        if (end_burst) begin
          state_next    = ST_IDLE;
          grant_next    = 2'b00;
          last_src_next = g_idx;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge fifo_wr_clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= 2'b00;
      last_src_reg <= 1'b1;
      beat_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_src_reg <= last_src_next;
      beat_reg     <= beat_next;
    end
  end

endmodule

// File: tb/tb_lcd_fifo_wr_arbiter.sv
// Bench for lcd_fifo_wr_arbiter: scenario tasks plus a cycle-level reference
// model that checks every cycle and logs one line per completed burst.
module tb_lcd_fifo_wr_arbiter;
  import lcd_pkg::*;

  localparam int DW = 24;
  localparam int BL = 64;
  localparam int AF = 768;
  localparam int AE = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_fifo_wr_arbiter_if #(.DATA_W(DW)) bus ();

  lcd_fifo_wr_arbiter #(
    .FIFO_ALMOSTFULL_DEPTH  (AF),
    .FIFO_ALMOSTEMPTY_DEPTH (AE),
    .BURST_LEN              (BL),
    .DATA_W                 (DW)
  ) dut (
    .fifo_wr_clk (clk),
    .rst         (rst),
    .bus         (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: owner is -1 when idle, otherwise the granted source.
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = 1;
  bit m_ready = 1'b0;

  int         obs_writes = 0;
  logic [1:0] prev_grant = 2'b00;
  int         burst_src_q[$];
  int         burst_len_q[$];

  always @(negedge clk) begin
    logic [1:0]    e_grant;
    logic [1:0]    e_req;
    logic          e_wr;
    logic [DW-1:0] e_din;
    bit            flow;
    e_grant = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    flow    = (m_owner >= 0) && m_ready && !bus.fifo_full && !rst;
    e_req   = flow ? e_grant : 2'b00;
    e_wr    = flow ? bus.src_data_en[m_owner] : 1'b0;
    e_din   = (m_owner >= 0 && !rst) ? ((m_owner == 1) ? bus.src_data1 : bus.src_data0) : '0;

    n_cmp++;
    if (bus.grant !== e_grant) begin
      n_fail++;
      $display("FAIL model_grant t=%0t got %b expected %b", $time, bus.grant, e_grant);
    end
    n_cmp++;
    if (bus.src_request !== e_req) begin
      n_fail++;
      $display("FAIL model_src_request t=%0t got %b expected %b", $time, bus.src_request, e_req);
    end
    n_cmp++;
    if (bus.fifo_wr_en !== e_wr) begin
      n_fail++;
      $display("FAIL model_wr_en t=%0t got %b expected %b", $time, bus.fifo_wr_en, e_wr);
    end
    n_cmp++;
    if (bus.fifo_din !== e_din) begin
      n_fail++;
      $display("FAIL model_din t=%0t got %h expected %h", $time, bus.fifo_din, e_din);
    end

    // Burst log built from what the DUT actually did.
    if (bus.grant !== prev_grant) begin
      if (prev_grant != 2'b00) begin
        burst_src_q.push_back(prev_grant[1] ? 1 : 0);
        burst_len_q.push_back(obs_writes);
        $display("burst src=%0d writes=%0d t=%0t", prev_grant[1] ? 1 : 0, obs_writes, $time);
      end
      obs_writes = 0;
      prev_grant = bus.grant;
    end
    if (bus.fifo_wr_en === 1'b1) obs_writes++;

    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_last  = 1;
      m_ready = 1'b0;
    end else begin
      if (m_owner < 0) begin
        if (m_ready && bus.src_req != 2'b00) begin
          if (bus.src_req == 2'b11) m_owner = 1 - m_last;
          else                      m_owner = (bus.src_req == 2'b01) ? 0 : 1;
          m_beats = 0;
        end
      end else if (e_wr) begin
        m_beats++;
        if (m_beats == BL || bus.src_last[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else if (!bus.src_req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
      if (bus.fifo_wr_cnt >= AF || bus.fifo_full) m_ready = 1'b0;
      else if (bus.fifo_wr_cnt < AE)              m_ready = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.src_data0 = DW'($urandom);
    bus.src_data1 = DW'($urandom);
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] en,
                       input logic [9:0] cnt, input logic full);
    bus.src_req     = req;
    bus.src_data_en = en;
    bus.src_last    = 2'b00;
    bus.fifo_wr_cnt = cnt;
    bus.fifo_full   = full;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 10'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    burst_src_q.delete();
    burst_len_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 2'b11, 10'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.grant !== 2'b00 || bus.src_request !== 2'b00 ||
          bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs got grant=%b req=%b wr=%b din=%h expected all zero",
                 bus.grant, bus.src_request, bus.fifo_wr_en, bus.fifo_din);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    bit done = 1'b0;
    do_reset();
    drive(2'b01, 2'b01, 10'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (burst_len_q.size() >= 1) begin done = 1'b1; break; end
    end
    bus.src_req = 2'b00;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL single_timeout got no burst end expected one within 300 cycles");
    end else if (burst_src_q[0] != 0 || burst_len_q[0] != BL) begin
      n_fail++;
      $display("FAIL single_burst got src=%0d writes=%0d expected src=0 writes=%0d",
               burst_src_q[0], burst_len_q[0], BL);
    end
    repeat (3) tick();
  endtask

  task automatic test_alternate();
    bit done = 1'b0;
    do_reset();
    drive(2'b11, 2'b11, 10'd0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      tick();
      if (burst_len_q.size() >= 4) begin done = 1'b1; break; end
    end
    bus.src_req = 2'b00;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL alternate_timeout got %0d bursts expected 4", burst_len_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (burst_src_q[i] != (i % 2) || burst_len_q[i] != BL) begin
          n_fail++;
          $display("FAIL alternate_burst%0d got src=%0d writes=%0d expected src=%0d writes=%0d",
                   i, burst_src_q[i], burst_len_q[i], i % 2, BL);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_watermark();
    bit hit = 1'b0;
    do_reset();
    drive(2'b01, 2'b01, 10'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.grant == 2'b01 && obs_writes == 20) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL watermark_timeout got writes=%0d expected 20", obs_writes);
    end
    bus.fifo_wr_cnt = 10'd768;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) bus.fifo_wr_cnt = 10'd500;
      @(negedge clk);
      n_cmp++;
      if (bus.src_request !== 2'b00 || bus.fifo_wr_en !== 1'b0 || bus.grant !== 2'b01) begin
        n_fail++;
        $display("FAIL watermark_pause got req=%b wr=%b grant=%b expected req=00 wr=0 grant=01",
                 bus.src_request, bus.fifo_wr_en, bus.grant);
      end
      tick();
    end
    bus.fifo_wr_cnt = 10'd127;
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.src_request !== 2'b01 || bus.fifo_wr_en !== 1'b1 || bus.grant !== 2'b01) begin
      n_fail++;
      $display("FAIL watermark_resume got req=%b wr=%b grant=%b expected req=01 wr=1 grant=01",
               bus.src_request, bus.fifo_wr_en, bus.grant);
    end
    tick();
    bus.src_req = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_last();
    bit done = 1'b0;
    bit got  = 1'b0;
    do_reset();
    drive(2'b10, 2'b11, 10'd0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (burst_len_q.size() >= 1) begin done = 1'b1; break; end
      if (bus.grant == 2'b10 && obs_writes == 5) bus.src_req = 2'b11;
      bus.src_last = (bus.grant == 2'b10 && obs_writes == 10) ? 2'b10 : 2'b00;
    end
    bus.src_last = 2'b00;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL last_timeout got no burst end expected one within 200 cycles");
    end else if (burst_src_q[0] != 1 || burst_len_q[0] != 11) begin
      n_fail++;
      $display("FAIL last_burst got src=%0d writes=%0d expected src=1 writes=11",
               burst_src_q[0], burst_len_q[0]);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.grant != 2'b00) begin got = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!got || bus.grant !== 2'b01) begin
      n_fail++;
      $display("FAIL last_next_grant got %b expected 01", bus.grant);
    end
    bus.src_req = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_full();
    bit hit = 1'b0;
    do_reset();
    drive(2'b01, 2'b01, 10'd0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (obs_writes >= 5) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL full_timeout got writes=%0d expected 5", obs_writes);
    end
    bus.fifo_full   = 1'b1;
    bus.fifo_wr_cnt = 10'd500;
    for (int i = 0; i < 20; i++) begin
      bus.src_data_en = 2'($urandom);
      @(negedge clk);
      n_cmp++;
      if (bus.fifo_wr_en !== 1'b0 || bus.src_request !== 2'b00 || bus.grant !== 2'b01) begin
        n_fail++;
        $display("FAIL full_block got wr=%b req=%b grant=%b expected wr=0 req=00 grant=01",
                 bus.fifo_wr_en, bus.src_request, bus.grant);
      end
      tick();
    end
    drive(2'b01, 2'b01, 10'd100, 1'b0);
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.fifo_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL full_resume got wr=%b expected 1", bus.fifo_wr_en);
    end
    tick();
    bus.src_data_en = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.fifo_wr_en !== 1'b0 || bus.grant !== 2'b01) begin
        n_fail++;
        $display("FAIL nongranted_en got wr=%b grant=%b expected wr=0 grant=01",
                 bus.fifo_wr_en, bus.grant);
      end
      tick();
    end
    bus.src_req = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    bit got = 1'b0;
    do_reset();
    drive(2'b01, 2'b01, 10'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.grant == 2'b01 && obs_writes == 30) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reset_mid_timeout got writes=%0d expected 30", obs_writes);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.fifo_wr_en !== 1'b0 || bus.src_request !== 2'b00 || bus.fifo_din !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_same_cycle got wr=%b req=%b din=%h expected all zero",
               bus.fifo_wr_en, bus.src_request, bus.fifo_din);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.grant !== 2'b00 || bus.fifo_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next_edge got grant=%b wr=%b expected grant=00 wr=0",
               bus.grant, bus.fifo_wr_en);
    end
    tick();
    rst = 1'b0;
    bus.src_req     = 2'b11;
    bus.src_data_en = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.grant != 2'b00) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got || bus.grant !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_tie got grant=%b expected 01", bus.grant);
    end
    bus.src_req = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [9:0] cnt_pick[8] = '{10'd0, 10'd100, 10'd127, 10'd128, 10'd500, 10'd767, 10'd768, 10'd1023};
    do_reset();
    drive(2'b11, 2'b11, 10'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) bus.src_req = 2'($urandom);
      bus.src_data_en = 2'($urandom);
      bus.src_last    = ($urandom_range(0, 31) == 0) ? 2'($urandom) : 2'b00;
      bus.fifo_full   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.fifo_wr_cnt = cnt_pick[$urandom_range(0, 7)];
        else                           bus.fifo_wr_cnt = 10'($urandom);
      end
    end
    rst = 1'b0;
    drive(2'b00, 2'b00, 10'd0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    drive(2'b00, 2'b00, 10'd0, 1'b0);
    bus.src_data0 = '0;
    bus.src_data1 = '0;
    test_reset();
    test_single();
    test_alternate();
    test_watermark();
    test_last();
    test_full();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
